// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle: the fetch stage is the master,
// instruction memory the slave.
interface fetch_stage_if #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 32
);
    logic               imem_req;
    logic [A_WIDTH-1:0] imem_addr;
    logic               imem_ready;
    logic [D_WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID register: owns PCF, runs the imem req/ready
// handshake, parks one response in a skid while decode stalls, applies redirects.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch_cnt/kill_cnt outputs.
module fetch_stage #(
    parameter int                 D_WIDTH  = 32,
    parameter int                 A_WIDTH  = 32,
    parameter logic [A_WIDTH-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               PCSrcE,
    input  logic [A_WIDTH-1:0] PCTargetE,
    input  logic               StallF,
    input  logic               StallD,
    input  logic               FlushD,
    fetch_stage_if.master      imem,
    output logic [D_WIDTH-1:0] InstrD,
    output logic [A_WIDTH-1:0] PCD,
    output logic [A_WIDTH-1:0] PCPlus4D,
    output logic               ValidD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        kill_cnt
`endif
);

    localparam logic [D_WIDTH-1:0] NOP_INSTR = D_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] pcF_q, pcF_d;
    logic               inFlight_q, inFlight_d;
    logic               redirPend_q, redirPend_d;
    logic [D_WIDTH-1:0] skidInstr_q, skidInstr_d;
    logic [A_WIDTH-1:0] skidPc_q, skidPc_d;
    logic [D_WIDTH-1:0] instrD_q, instrD_d;
    logic [A_WIDTH-1:0] pcD_q, pcD_d;
    logic [A_WIDTH-1:0] pcPlus4D_q, pcPlus4D_d;
    logic               validD_q, validD_d;

    logic               reqOut;
    logic               fire;
    logic               killResp;
    logic               take;
    logic [A_WIDTH-1:0] pcPlus4F;
    logic [A_WIDTH-1:0] targetPc;
    logic               unusedTargetLsbs;

    // A request already presented without ready stays up even under StallF,
    // so the handshake is never withdrawn half-way.
    always_comb begin
        reqOut   = (state_q == S_REQ) && (!StallF || inFlight_q);
        fire     = reqOut && imem.imem_ready;
        killResp = PCSrcE || redirPend_q;
        take     = fire && !killResp;
        pcPlus4F = pcF_q + A_WIDTH'(4);
        targetPc = {PCTargetE[A_WIDTH-1:2], 2'b00};
    end

    assign unusedTargetLsbs = ^PCTargetE[1:0];

    assign imem.imem_req  = reqOut;
    assign imem.imem_addr = pcF_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ:   if (take && StallD) state_d = S_HOLD;
            S_HOLD:  if (!StallD) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
        if (PCSrcE) begin
            state_d = S_REQ;
        end
    end

    always_comb begin
        pcF_d       = pcF_q;
        inFlight_d  = reqOut && !imem.imem_ready;
        redirPend_d = redirPend_q;
        if (PCSrcE) begin
            pcF_d = targetPc;
        end else if (take && !StallF) begin
            pcF_d = pcPlus4F;
        end
        // The stale response still owed by memory must be swallowed on arrival.
        if (PCSrcE && reqOut && !imem.imem_ready) begin
            redirPend_d = 1'b1;
        end else if (fire) begin
            redirPend_d = 1'b0;
        end
    end

    always_comb begin
        skidInstr_d = skidInstr_q;
        skidPc_d    = skidPc_q;
        if ((state_q == S_REQ) && take && StallD) begin
            skidInstr_d = imem.imem_rdata;
            skidPc_d    = pcF_q;
        end
    end

    always_comb begin
        instrD_d   = instrD_q;
        pcD_d      = pcD_q;
        pcPlus4D_d = pcPlus4D_q;
        validD_d   = validD_q;
        if (FlushD) begin
            instrD_d   = NOP_INSTR;
            pcD_d      = '0;
            pcPlus4D_d = '0;
            validD_d   = 1'b0;
        end else if (!StallD) begin
            instrD_d   = NOP_INSTR;
            pcD_d      = '0;
            pcPlus4D_d = '0;
            validD_d   = 1'b0;
            if ((state_q == S_HOLD) && !PCSrcE) begin
                instrD_d   = skidInstr_q;
                pcD_d      = skidPc_q;
                pcPlus4D_d = skidPc_q + A_WIDTH'(4);
                validD_d   = 1'b1;
            end else if ((state_q == S_REQ) && take) begin
                instrD_d   = imem.imem_rdata;
                pcD_d      = pcF_q;
                pcPlus4D_d = pcPlus4F;
                validD_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pcF_q       <= RESET_PC;
            inFlight_q  <= 1'b0;
            redirPend_q <= 1'b0;
            skidInstr_q <= '0;
            skidPc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pcF_q       <= pcF_d;
            inFlight_q  <= inFlight_d;
            redirPend_q <= redirPend_d;
            skidInstr_q <= skidInstr_d;
            skidPc_q    <= skidPc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instrD_q   <= NOP_INSTR;
            pcD_q      <= '0;
            pcPlus4D_q <= '0;
            validD_q   <= 1'b0;
        end else begin
            instrD_q   <= instrD_d;
            pcD_q      <= pcD_d;
            pcPlus4D_q <= pcPlus4D_d;
            validD_q   <= validD_d;
        end
    end

    assign InstrD   = instrD_q;
    assign PCD      = pcD_q;
    assign PCPlus4D = pcPlus4D_q;
    assign ValidD   = validD_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetchCnt_q, fetchCnt_d;
    logic [31:0] killCnt_q, killCnt_d;
    logic        discardResp;
    logic [1:0]  killIncr;
    logic [32:0] killSum;

    // A response is lost by a kill, by a flush on its way into decode, or by a
    // skid entry dropped through redirect or flush.
    always_comb begin
        discardResp = (fire && killResp)
                   || (take && !StallD && FlushD)
                   || ((state_q == S_HOLD) && (PCSrcE || (!StallD && FlushD)));
        killIncr    = 2'(discardResp) + 2'(FlushD && validD_q);
        killSum     = {1'b0, killCnt_q} + 33'(killIncr);
        fetchCnt_d  = fetchCnt_q;
        if (take && (fetchCnt_q != '1)) begin
            fetchCnt_d = fetchCnt_q + 32'd1;
        end
        killCnt_d = killSum[32] ? '1 : killSum[31:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetchCnt_q <= '0;
            killCnt_q  <= '0;
        end else begin
            fetchCnt_q <= fetchCnt_d;
            killCnt_q  <= killCnt_d;
        end
    end

    assign fetch_cnt = fetchCnt_q;
    assign kill_cnt  = killCnt_q;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the reduced pipelined RISC-V core. It owns the PC, issues requests to instruction memory through a req/ready handshake, and applies redirects from execute. It delivers InstrD/PCD/PCPlus4D to the decode stage, whose main decoder consumes InstrD. It honours hazard-unit stall and flush signals and inserts NOPs where needed.

Parameters:
D_WIDTH, 32, instruction/data width
A_WIDTH, 32, PC and address width
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
PCSrcE  in  1  redirect taken (branch/JAL/JALR resolved in execute)
PCTargetE  in  A_WIDTH  redirect target
StallF  in  1  hold PC, issue no new request
StallD  in  1  hold IF/ID register
FlushD  in  1  replace IF/ID contents with NOP
imem_req  out  1  fetch request valid
imem_addr  out  A_WIDTH  fetch address (= PCF)
imem_ready  in  1  response valid this cycle, data on imem_rdata
imem_rdata  in  D_WIDTH  fetched instruction
InstrD  out  D_WIDTH  instruction to decode
PCD  out  A_WIDTH  PC of InstrD
PCPlus4D  out  A_WIDTH  PCD + 4
ValidD  out  1  InstrD is a real instruction (0 = bubble)

Behaviour:
- Reset (async, rst_n=0): PCF=RESET_PC; state=S_IDLE; imem_req=0; InstrD=32'h0000_0013 (NOP, addi x0,x0,0); PCD=0; PCPlus4D=0; ValidD=0; skid empty; redirect-pending=0.
- FSM states:
  - S_IDLE: first cycle after reset release; req=0; go to S_REQ.
  - S_REQ: req=1, addr=PCF.
  - S_HOLD: response buffered in skid, waiting for StallD=0; req=0.
- Handshake: while req=1, addr stays stable until imem_ready=1. A response is accepted only in the cycle with req=1 and ready=1.
- S_REQ, ready=1, StallD=0, no kill:
  - Next edge loads InstrD=rdata, PCD=PCF, PCPlus4D=PCF+4, ValidD=1.
  - PCF advances to PCF+4 unless StallF=1.
  - FSM stays in S_REQ, so a zero-wait memory gives 1 instruction per cycle with 1-cycle latency from ready to InstrD.
- S_REQ, ready=1, StallD=1: response goes to skid (instr and PC); FSM goes to S_HOLD; PCF advances unless StallF=1.
- S_REQ, ready=0 with StallD=0: ValidD=0 on next edge (bubble, InstrD=NOP). With StallD=1, IF/ID holds.
- S_HOLD, StallD=0: skid loads into IF/ID with ValidD=1; skid empties; FSM goes to S_REQ. With StallD=1, everything holds.
- StallF=1 in S_REQ before a response: req drops to 0 and PCF holds. When StallF falls, req reasserts at the same PCF. Exception: if req=1 was already presented this cycle without ready, req stays high (the request is not withdrawn mid-handshake).
- Redirect (PCSrcE=1), highest priority:
  - PCF<=PCTargetE regardless of StallF.
  - Skid is discarded; FSM goes to S_REQ.
  - If a request is outstanding without ready, set redirect-pending. The in-flight response is then discarded on arrival, and the next request uses the new PCF.
  - A response arriving in the same cycle as PCSrcE=1 is discarded.
- FlushD=1: IF/ID loads NOP, ValidD=0, PCD=0, PCPlus4D=0. FlushD overrides StallD and skid transfer. It does not touch PCF.
- Arithmetic: PC+4 is modulo 2^A_WIDTH; wrap from 32'hFFFF_FFFC to 0 is legal. PCTargetE bits [1:0] are forced to 0.
- Reset mid-handshake: all state clears immediately; any late ready is ignored until S_REQ.

Optional Feature:
- FETCH_PERF_CNT_EN defined: adds outputs fetch_cnt and kill_cnt, each 32 bits, reset to 0, saturating at all-ones.
  - fetch_cnt increments per accepted response.
  - kill_cnt increments per discarded response plus per FlushD cycle with ValidD=1.
- Undefined: ports and counters are absent, with no behavioural change.

Test Plan:
- Reset release, imem_ready tied 1, RESET_PC=0 -> imem_addr 0,4,8,… on consecutive cycles; InstrD follows one cycle later; PCPlus4D=PCD+4; ValidD=1 from cycle 3.
- ready low for 3 cycles at addr 8 -> imem_addr held at 8, req held 1, ValidD=0 for 3 cycles, then InstrD=mem[8].
- StallD=1 for 2 cycles while response at addr 12 arrives -> FSM S_HOLD, InstrD unchanged; after release InstrD=mem[12], PCD=12, no instruction lost or duplicated.
- PCSrcE=1, PCTargetE=0x40 while request at 0x10 is outstanding (ready delayed 2 cycles) -> 0x10 response discarded; next req at 0x40; InstrD=mem[0x40].
- FlushD=1 together with StallD=1 -> InstrD=32'h13, ValidD=0, PCD=0; PCF unchanged.
- Assert rst_n=0 mid-wait -> outputs at reset values within the same cycle; restart from RESET_PC.
